// File: rtl/filter_pkg.sv
// Shared definitions for the video filter stage: coordinate width, divider
// FSM states and channel lane indices for the RGB and RBG packings.
package filter_pkg;

    localparam int COORD_WIDTH = 11;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        DONE
    } div_state_t;

    // Lane index counted from the LSB lane of a 3-channel pixel word
    localparam int RGB_R = 2;
    localparam int RGB_G = 1;
    localparam int RGB_B = 0;

    localparam int RBG_R = 2;
    localparam int RBG_B = 1;
    localparam int RBG_G = 0;

    // Lane of the stream word (RBG) that carries a given output (RGB) channel
    function automatic int rgb_src_lane(input int rgb_idx);
        case (rgb_idx)
            RGB_R:   return RBG_R;
            RGB_G:   return RBG_G;
            default: return RBG_B;
        endcase
    endfunction

endpackage

// File: rtl/avg_divider.sv
// Sequential restoring divider: one quotient bit per cycle, MSB first.
// Loads dividend/divisor on start_i; done_o flags the cycle of the final step.
module avg_divider #(
    parameter int SUM_W = 30,
    parameter int CNT_W = 22,
    parameter int Q_W   = 8
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             start_i,
    input  logic [SUM_W-1:0] dividend_i,
    input  logic [CNT_W-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [Q_W-1:0]   quotient_o
);

    localparam int STEP_W = (Q_W > 1) ? $clog2(Q_W) : 1;

    logic [SUM_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  den_q, den_d;
    logic [Q_W-1:0]    quo_q, quo_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              busy_q, busy_d;
    logic [SUM_W-1:0]  trial;

    always_comb begin
        rem_d  = rem_q;
        den_d  = den_q;
        quo_d  = quo_q;
        step_d = step_q;
        busy_d = busy_q;
        // Mean never exceeds the channel maximum, so divisor << step cannot overflow SUM_W
        trial  = SUM_W'(den_q) << step_q;
        if (start_i) begin
            rem_d  = dividend_i;
            den_d  = divisor_i;
            quo_d  = '0;
            step_d = STEP_W'(Q_W - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (rem_q >= trial) begin
                rem_d         = rem_q - trial;
                quo_d[step_q] = 1'b1;
            end
            if (step_q == '0) begin
                busy_d = 1'b0;
            end else begin
                step_d = step_q - STEP_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rem_q  <= '0;
            den_q  <= '0;
            quo_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            den_q  <= den_d;
            quo_q  <= quo_d;
            step_q <= step_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = busy_q && (step_q == '0);
    assign quotient_o = quo_q;

endmodule

// File: rtl/frame_avg_color.sv
// Passive per-frame colour averager snooping an AXI4-Stream video bus.
// Optional `AVG_SUBSAMPLE_EN accumulates only even-column/even-line beats.
module frame_avg_color
    import filter_pkg::*;
#(
    parameter int COLOR_WIDTH  = 8,
    parameter int FRAME_WIDTH  = 1920,
    parameter int FRAME_HEIGHT = 1080,
    parameter int CNT_WIDTH    = 22
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic [3*COLOR_WIDTH-1:0] video_in_tdata,
    input  logic                     video_in_tlast,
    input  logic                     video_in_tuser,
    input  logic                     video_in_tvalid,
    input  logic                     video_in_tready,
    output logic [COORD_WIDTH-1:0]   video_in_X,
    output logic [COORD_WIDTH-1:0]   video_in_Y,
    output logic [3*COLOR_WIDTH-1:0] avg_color,
    output logic                     avg_valid,
    output logic                     err_overrun
);

    localparam int SUM_W = COLOR_WIDTH + CNT_WIDTH;
    localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(FRAME_HEIGHT - 1);

    logic [COORD_WIDTH-1:0] x_q, x_d, y_q, y_d;
    logic [COORD_WIDTH-1:0] cur_x, cur_y;
    logic [SUM_W-1:0]       sum_q [3];
    logic [SUM_W-1:0]       sum_d [3];
    logic [SUM_W-1:0]       sum_now [3];
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_now;
    logic                   accept, sof, frame_end, sample_en, div_start;
    div_state_t             state_q;
    logic [COLOR_WIDTH-1:0] quo [3];
    logic [2:0]             div_busy, div_done;
    logic                   div_unused;

    assign accept    = video_in_tvalid && video_in_tready;
    assign sof       = accept && video_in_tuser;
    assign cur_x     = sof ? '0 : x_q;
    assign cur_y     = sof ? '0 : y_q;
    assign frame_end = accept && video_in_tlast && (cur_y == Y_LAST);
    assign div_start = frame_end && (state_q == IDLE);

    assign video_in_X = cur_x;
    assign video_in_Y = cur_y;

`ifdef AVG_SUBSAMPLE_EN
    assign sample_en = !cur_x[0] && !cur_y[0];
`else
    assign sample_en = 1'b1;
`endif

    // A start-of-frame beat drops the partial sums and seeds the new frame
    assign cnt_now = (sof ? '0 : cnt_q) + CNT_WIDTH'(sample_en);

    for (genvar c = 0; c < 3; c++) begin : g_chan
        localparam int LANE = rgb_src_lane(c);
        logic [COLOR_WIDTH-1:0] pix;

        assign pix        = video_in_tdata[LANE*COLOR_WIDTH +: COLOR_WIDTH];
        assign sum_now[c] = (sof ? '0 : sum_q[c]) + (sample_en ? SUM_W'(pix) : '0);

        avg_divider #(
            .SUM_W (SUM_W),
            .CNT_W (CNT_WIDTH),
            .Q_W   (COLOR_WIDTH)
        ) u_div (
            .clk        (clk),
            .aresetn    (aresetn),
            .start_i    (div_start),
            .dividend_i (sum_now[c]),
            .divisor_i  (cnt_now),
            .busy_o     (div_busy[c]),
            .done_o     (div_done[c]),
            .quotient_o (quo[c])
        );
    end

    // All channels step in lockstep; only channel R's handshake is consumed
    assign div_unused = ^{div_busy, div_done[RGB_G], div_done[RGB_B]};

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        sum_d = sum_q;
        cnt_d = cnt_q;
        if (accept) begin
            if (video_in_tlast) begin
                x_d = '0;
                y_d = (cur_y == Y_LAST) ? '0 : cur_y + COORD_WIDTH'(1);
            end else begin
                x_d = (cur_x >= X_LAST) ? X_LAST : cur_x + COORD_WIDTH'(1);
                y_d = cur_y;
            end
            if (frame_end) begin
                for (int c = 0; c < 3; c++) sum_d[c] = '0;
                cnt_d = '0;
            end else begin
                sum_d = sum_now;
                cnt_d = cnt_now;
            end
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            x_q   <= '0;
            y_q   <= '0;
            cnt_q <= '0;
            for (int c = 0; c < 3; c++) sum_q[c] <= '0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            cnt_q <= cnt_d;
            sum_q <= sum_d;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            avg_color   <= '0;
            avg_valid   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (frame_end && (state_q != IDLE)) begin
                err_overrun <= 1'b1;
            end
            case (state_q)
                IDLE: if (div_start) state_q <= DIV;
                DIV:  if (div_done[RGB_R]) state_q <= DONE;
                DONE: begin
                    avg_color <= {quo[RGB_R], quo[RGB_G], quo[RGB_B]};
                    avg_valid <= 1'b1;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_avg_color.sv
// Bench for frame_avg_color on a 4x2 frame: table vectors, corner sequences
// and randomized frames against a plain-arithmetic mean model.
module tb_frame_avg_color;

    localparam int CW = 8;
    localparam int FW = 4;
    localparam int FH = 2;
    localparam int LAT = 9;

    logic          clk = 1'b0;
    logic          aresetn;
    logic [23:0]   video_in_tdata;
    logic          video_in_tlast, video_in_tuser, video_in_tvalid, video_in_tready;
    logic [10:0]   video_in_X, video_in_Y;
    logic [23:0]   avg_color;
    logic          avg_valid, err_overrun;

    always #5 clk = ~clk;

    frame_avg_color #(
        .COLOR_WIDTH  (CW),
        .FRAME_WIDTH  (FW),
        .FRAME_HEIGHT (FH),
        .CNT_WIDTH    (22)
    ) dut (
        .clk             (clk),
        .aresetn         (aresetn),
        .video_in_tdata  (video_in_tdata),
        .video_in_tlast  (video_in_tlast),
        .video_in_tuser  (video_in_tuser),
        .video_in_tvalid (video_in_tvalid),
        .video_in_tready (video_in_tready),
        .video_in_X      (video_in_X),
        .video_in_Y      (video_in_Y),
        .avg_color       (avg_color),
        .avg_valid       (avg_valid),
        .err_overrun     (err_overrun)
    );

    typedef struct { logic [23:0] d; bit last; bit user; } bt_t;
    typedef struct { logic [23:0] val; int c; } ev_t;
    typedef struct { logic [23:0] a; logic [23:0] b; logic [23:0] exp; } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   mx, my, last_acc;
    bit   prev_v = 1'b0;
    bt_t  fr[$];
    ev_t  obs_q[$];
    ev_t  exp_q[$];
    vec_t tbl[5];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (avg_valid) begin
            obs_q.push_back('{val: avg_color, c: cyc});
            n_vec++;
            if (prev_v) begin
                n_bad++;
                $display("FAIL pulse_width: avg_valid high on two consecutive cycles at cycle %0d", cyc);
            end
        end
        prev_v = avg_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Mean of a list of {R,B,G} beats, returned in {R,G,B} order
    function automatic logic [23:0] model_avg(input bt_t q[$]);
        int sr = 0, sg = 0, sb = 0, n = 0;
        foreach (q[i]) begin
            sr += int'(q[i].d[23:16]);
            sb += int'(q[i].d[15:8]);
            sg += int'(q[i].d[7:0]);
            n++;
        end
        return {8'(sr / n), 8'(sg / n), 8'(sb / n)};
    endfunction

    task automatic beat(input logic [23:0] d, input bit last, input bit user, input bit rdy);
        video_in_tvalid = 1'b1;
        video_in_tready = rdy;
        video_in_tdata  = d;
        video_in_tlast  = last;
        video_in_tuser  = user;
        #1;
        if (rdy) begin
            if (user) begin
                mx = 0;
                my = 0;
            end
            chk("coord_X", 32'(video_in_X), mx);
            chk("coord_Y", 32'(video_in_Y), my);
        end
        @(posedge clk);
        #1;
        if (rdy) begin
            last_acc = cyc;
            if (last) begin
                mx = 0;
                my = (my == FH - 1) ? 0 : my + 1;
            end else begin
                mx = (mx + 1 > FW - 1) ? FW - 1 : mx + 1;
            end
        end
    endtask

    task automatic idle(input int n);
        video_in_tvalid = 1'b0;
        video_in_tuser  = 1'b0;
        video_in_tlast  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic mk_frame(input logic [23:0] a, input logic [23:0] b);
        fr.delete();
        for (int i = 0; i < FW * FH; i++)
            fr.push_back('{d: (i % 2 == 0) ? a : b, last: (i % FW == FW - 1), user: (i == 0)});
    endtask

    // mode 0: full rate, 1: tready toggles 0/1, 2: random stalls
    task automatic send(input int mode);
        foreach (fr[i]) begin
            int stalls;
            stalls = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int s = 0; s < stalls; s++) beat(fr[i].d, fr[i].last, fr[i].user, 1'b0);
            beat(fr[i].d, fr[i].last, fr[i].user, 1'b1);
        end
    endtask

    task automatic expect_avg(input logic [23:0] v);
        exp_q.push_back('{val: v, c: last_acc + LAT});
    endtask

    task automatic drain();
        idle(25);
        chk("n_pulses", obs_q.size(), exp_q.size());
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o, e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            chk("avg_color", 32'(o.val), 32'(e.val));
            chk("latency", o.c, e.c);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [23:0] v;

        tbl[0] = '{a: 24'h402010, b: 24'h402010, exp: 24'h401020};
        tbl[1] = '{a: 24'h000000, b: 24'hFF0000, exp: 24'h7F0000};
        tbl[2] = '{a: 24'hFFFFFF, b: 24'hFFFFFF, exp: 24'hFFFFFF};
        tbl[3] = '{a: 24'h000003, b: 24'h000000, exp: 24'h000100};
        tbl[4] = '{a: 24'h0A141E, b: 24'h000000, exp: 24'h050F0A};

        aresetn = 1'b0;
        video_in_tdata = '0;
        video_in_tlast = 1'b0;
        video_in_tuser = 1'b0;
        video_in_tvalid = 1'b0;
        video_in_tready = 1'b0;
        mx = 0;
        my = 0;
        last_acc = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_avg_color", 32'(avg_color), 0);
        chk("rst_avg_valid", 32'(avg_valid), 0);
        chk("rst_err", 32'(err_overrun), 0);
        chk("rst_X", 32'(video_in_X), 0);
        chk("rst_Y", 32'(video_in_Y), 0);
        aresetn = 1'b1;
        idle(2);

        for (int i = 0; i < 5; i++) begin
            mk_frame(tbl[i].a, tbl[i].b);
            send(0);
            expect_avg(tbl[i].exp);
            drain();
        end
        chk("err_after_table", 32'(err_overrun), 0);

        // tready toggling: same mean as the uniform frame
        mk_frame(24'h402010, 24'h402010);
        send(1);
        expect_avg(24'h401020);
        drain();

        // Partial frame of bright beats, then a restart with tuser
        for (int i = 0; i < 3; i++) beat(24'hFFFFFF, 1'b0, i == 0, 1'b1);
        mk_frame(24'h402010, 24'h402010);
        send(0);
        expect_avg(24'h401020);
        drain();

        // Restart during division must not disturb the job in flight
        mk_frame(24'h402010, 24'h402010);
        send(0);
        expect_avg(24'h401020);
        beat(24'hFFFFFF, 1'b0, 1'b1, 1'b1);
        beat(24'hFFFFFF, 1'b0, 1'b0, 1'b1);
        mk_frame(24'h0A141E, 24'h000000);
        send(0);
        expect_avg(24'h050F0A);
        drain();

        // Overlong first line: X saturates, extra beats still counted
        fr.delete();
        for (int i = 0; i < 10; i++)
            fr.push_back('{d: {8'(i * 20), 8'(i * 3), 8'(i)}, last: (i == 5 || i == 9), user: (i == 0)});
        send(0);
        expect_avg(model_avg(fr));
        drain();

        // Back-to-back frames at half rate leave the divider time to finish
        mk_frame(24'h101010, 24'h101010);
        send(1);
        expect_avg(24'h101010);
        mk_frame(24'h808080, 24'h808080);
        send(1);
        expect_avg(24'h808080);
        drain();
        chk("err_b2b_halfrate", 32'(err_overrun), 0);

        for (int f = 0; f < 6; f++) begin
            fr.delete();
            for (int i = 0; i < FW * FH; i++)
                fr.push_back('{d: 24'($urandom), last: (i % FW == FW - 1), user: (i == 0)});
            send(2);
            expect_avg(model_avg(fr));
            idle($urandom_range(2, 5));
        end
        drain();
        chk("err_random", 32'(err_overrun), 0);

        // Full-rate back-to-back: second frame ends mid-divide and is dropped
        mk_frame(24'h101010, 24'h101010);
        send(0);
        expect_avg(24'h101010);
        mk_frame(24'h808080, 24'h808080);
        send(0);
        drain();
        chk("err_overrun_set", 32'(err_overrun), 1);

        // Reset in the middle of a division
        mk_frame(24'hFFFFFF, 24'hFFFFFF);
        send(0);
        idle(4);
        aresetn = 1'b0;
        #1;
        chk("rst_mid_avg_color", 32'(avg_color), 0);
        chk("rst_mid_err", 32'(err_overrun), 0);
        chk("rst_mid_valid", 32'(avg_valid), 0);
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        mx = 0;
        my = 0;
        drain();
        mk_frame(24'h0A141E, 24'h000000);
        send(0);
        expect_avg(24'h050F0A);
        drain();
        v = avg_color;
        idle(5);
        chk("avg_hold", 32'(avg_color), 32'(v));
        chk("avg_hold_value", 32'(avg_color), 32'h050F0A);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
